// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving a shared-resource mux select
//
// Grants one of NUM_REQ requesters at a time and holds the grant until done,
// until the owner withdraws its request, or until HOLD_MAX cycles have elapsed.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [NUM_REQ] request vector, bit i = requester i
//   done     in   completion pulse for the current transaction
//   grant    out  [NUM_REQ] registered one-hot grant, zero when idle
//   sel      out  [SEL_W] registered binary index of the granted requester
//   busy     out  high while a grant is active
//   timeout  out  one-cycle pulse on forced release at HOLD_MAX
//   abort    out  one-cycle pulse on release because the owner dropped req

module rr_mux_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = $clog2(NUM_REQ) + 1,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = $clog2(HOLD_MAX) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout,
  output logic               abort
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_timeout;
  logic               r_abort;

  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               w_timeout_nxt;
  logic               w_abort_nxt;

  logic [NUM_REQ-1:0] w_mask_hi;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [SEL_W-1:0]   w_hi_idx;
  logic [SEL_W-1:0]   w_lo_idx;
  logic [SEL_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic               w_owner_req;
  logic               w_hold_hit;
  logic [SEL_W-1:0]   w_ptr_adv;

  // Round-robin search: prefer the lowest set bit at or above ptr; if none,
  // wrap around and take the lowest set bit overall.
  always_comb begin
    w_mask_hi = '0;
    w_hi_idx  = '0;
    w_lo_idx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_mask_hi[j] = (SEL_W'(j) >= r_ptr);
    end
    w_req_hi = req & w_mask_hi;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_req_hi[j]) w_hi_idx = SEL_W'(j);
      if (req[j])      w_lo_idx = SEL_W'(j);
    end
    w_win        = (|w_req_hi) ? w_hi_idx : w_lo_idx;
    w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  end

  // Owner still requesting: masking with the current one-hot grant avoids
  // indexing req by the wider select value.
  assign w_owner_req = |(req & r_grant);
  assign w_hold_hit  = (r_cnt == CNT_W'(HOLD_MAX - 1));
  assign w_ptr_adv   = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_timeout_nxt = 1'b0;
    w_abort_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win_onehot;
          w_sel_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        if (done || !w_owner_req || w_hold_hit) begin
          // done outranks both abort and timeout when they coincide
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_ptr_nxt     = w_ptr_adv;
          w_cnt_nxt     = '0;
          w_abort_nxt   = !done && !w_owner_req;
          w_timeout_nxt = !done && w_owner_req && w_hold_hit;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_timeout <= w_timeout_nxt;
      r_abort   <= w_abort_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = (r_state == ST_BUSY);
  assign timeout = r_timeout;
  assign abort   = r_abort;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  localparam int N     = 4;
  localparam int HMAX  = 8;
  localparam int SW    = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          done = 1'b0;
  logic [N-1:0]  grant;
  logic [SW-1:0] sel;
  logic          busy;
  logic          timeout;
  logic          abort;

  int n_vec = 0;
  int n_err = 0;

  rr_mux_arbiter #(.NUM_REQ(N), .HOLD_MAX(HMAX)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .sel(sel), .busy(busy), .timeout(timeout), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the resource, how many cycles the
  // grant has been visible, and the next starting point of the search.
  bit           m_valid = 0;
  bit           m_busy;
  int           m_w, m_ptr, m_held;
  bit [N-1:0]   e_grant;
  int           e_sel;
  bit           e_to, e_ab;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_w = 0; m_ptr = 0; m_held = 0;
      e_grant = '0; e_sel = 0; e_to = 0; e_ab = 0;
      m_valid = 1;
    end else if (m_valid) begin
      e_to = 0;
      e_ab = 0;
      if (!m_busy) begin
        if (req != 0) begin
          bit found;
          found = 0;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && req[c]) begin
              found = 1;
              m_w = c;
            end
          end
          m_busy  = 1;
          m_held  = 1;
          e_grant = '0;
          e_grant[m_w] = 1'b1;
          e_sel   = m_w;
        end
      end else begin
        if (done || !req[m_w] || m_held == HMAX) begin
          e_ab    = !done && !req[m_w];
          e_to    = !done && req[m_w];
          m_busy  = 0;
          e_grant = '0;
          m_ptr   = (m_w + 1) % N;
        end else begin
          m_held++;
        end
      end
    end
  end

  // Compare process plus invariants and a fairness watch driven by DUT grants.
  bit [N-1:0] s_req = '0;
  bit [N-1:0] prev_grant = '0;
  int         wait_cnt [N];

  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant", int'(grant), int'(e_grant));
      chk("sel", int'(sel), e_sel);
      chk("busy", int'(busy), int'(m_busy));
      chk("timeout", int'(timeout), int'(e_to));
      chk("abort", int'(abort), int'(e_ab));
      chk("inv_onehot", int'($countones(grant) <= 1), 1);
      chk("inv_busy", int'(busy), int'(|grant));
      chk("inv_excl", int'(timeout && abort), 0);
      chk("inv_sel", int'(int'(sel) < N), 1);
      if (rst) begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) if (!s_req[i]) wait_cnt[i] = 0;
        if (prev_grant == 0 && grant != 0) begin
          for (int i = 0; i < N; i++) begin
            if (grant[i]) wait_cnt[i] = 0;
            else if (s_req[i]) begin
              wait_cnt[i]++;
              chk("fairness", int'(wait_cnt[i] <= N - 1), 1);
            end
          end
        end
      end
      prev_grant = grant;
    end
    s_req = req;
  end

  task automatic cyc(input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc('0, 1'b0);
    rst = 1'b0;
  endtask

  logic [N-1:0] exp_order [5];

  initial begin
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

    // Reset state
    do_reset();
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);

    // Two requesters, done three cycles after grant, then the other wins
    cyc(4'b0101, 1'b0);
    chk("t1_grant", int'(grant), 1);
    chk("t1_sel", int'(sel), 0);
    chk("t1_busy", int'(busy), 1);
    cyc(4'b0101, 1'b0);
    cyc(4'b0101, 1'b0);
    cyc(4'b0101, 1'b1);
    chk("t1_release", int'(grant), 0);
    cyc(4'b0101, 1'b0);
    chk("t1_grant2", int'(grant), 4);
    chk("t1_sel2", int'(sel), 2);
    cyc(4'b0000, 1'b1);

    // Rotation with all requesters held
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 1'b0);
      chk("t2_order", int'(grant), int'(exp_order[g]));
      cyc(4'b1111, 1'b1);
      chk("t2_gap", int'(grant), 0);
    end
    cyc(4'b0000, 1'b0);

    // Hold timeout on a single requester
    do_reset();
    cyc(4'b0010, 1'b0);
    chk("t3_grant", int'(grant), 2);
    for (int c = 0; c < HMAX - 1; c++) cyc(4'b0010, 1'b0);
    chk("t3_held8", int'(grant), 2);
    chk("t3_no_to", int'(timeout), 0);
    cyc(4'b0010, 1'b0);
    chk("t3_timeout", int'(timeout), 1);
    chk("t3_rel", int'(grant), 0);
    cyc(4'b0010, 1'b0);
    chk("t3_regrant", int'(grant), 2);
    chk("t3_to_clr", int'(timeout), 0);
    cyc(4'b0000, 1'b1);

    // Abort when owner drops, and done masking the abort
    do_reset();
    cyc(4'b1000, 1'b0);
    chk("t4_grant", int'(grant), 8);
    cyc(4'b1000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("t4_abort", int'(abort), 1);
    chk("t4_rel", int'(grant), 0);
    cyc(4'b0000, 1'b0);
    chk("t4_abort_clr", int'(abort), 0);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    cyc(4'b0000, 1'b1);
    chk("t4_done_abort", int'(abort), 0);
    chk("t4_done_rel", int'(grant), 0);

    // Reset mid-transaction
    do_reset();
    cyc(4'b0100, 1'b0);
    chk("t5_grant", int'(grant), 4);
    cyc(4'b0100, 1'b0);
    rst = 1'b1;
    cyc(4'b1111, 1'b0);
    chk("t5_rst_grant", int'(grant), 0);
    chk("t5_rst_busy", int'(busy), 0);
    rst = 1'b0;
    cyc(4'b1111, 1'b0);
    chk("t5_first", int'(grant), 1);
    cyc(4'b0000, 1'b1);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      cyc(N'($urandom), ($urandom_range(0, 3) == 0));
    end
    rst = 1'b0;
    cyc('0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource (e.g. a memory or register-file port) among NUM_REQ requesters.
- Drives the select input of the team's generic N-input mux in front of that resource, and issues a one-hot grant back to the winning requester.
- Holds the grant for a multi-cycle transaction until the resource signals completion, the requester withdraws, or a hold timeout expires.

Parameters:
- NUM_REQ, default 4: number of requesters and mux inputs; must be ≥2.
- SEL_W, default $clog2(NUM_REQ)+1: select width, matching the generic mux select port.
- HOLD_MAX, default 8: maximum cycles a grant may be held without done; must be ≥1.
- CNT_W, default $clog2(HOLD_MAX)+1: width of the hold counter.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: request vector; bit i is requester i.
- done, input, 1: resource completion pulse for the current transaction.
- grant, output, NUM_REQ: registered one-hot grant; all zero when idle.
- sel, output, SEL_W: registered binary index of the granted requester, driven to the mux select.
- busy, output, 1: high while any grant is active.
- timeout, output, 1: one-cycle pulse when a grant is forcibly released at HOLD_MAX.
- abort, output, 1: one-cycle pulse when a grant is released because its requester dropped req.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of current state:
  - grant=0, sel=0, busy=0, timeout=0, abort=0.
  - FSM=IDLE, priority pointer ptr=0, hold counter=0.
  - An in-flight grant is dropped with no timeout or abort pulse.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req≠0, select the first set bit searching ptr, ptr+1, …, NUM_REQ-1, 0, …, with wrap-around.
  - Next cycle: grant=onehot(winner), sel=winner, busy=1, counter=0, FSM→BUSY.
  - Latency from req sampled in IDLE to grant visible is 1 cycle.
  - If req=0, stay in IDLE with outputs 0.
- BUSY (winner w): each cycle, exactly one release condition applies, evaluated in priority order:
  1. done=1: release next cycle (grant=0, busy=0), ptr←(w+1) mod NUM_REQ, FSM→IDLE.
  2. Else req[w]=0: release, abort=1 for one cycle, ptr←(w+1) mod NUM_REQ, FSM→IDLE.
  3. Else counter=HOLD_MAX-1: release, timeout=1 for one cycle, ptr←(w+1) mod NUM_REQ, FSM→IDLE.
  4. Otherwise counter increments; grant and sel are held stable.
- After any release, exactly one IDLE cycle with grant=0 precedes the next grant. There are no back-to-back grants.
- Simultaneous done and req[w] drop in the same cycle counts as a normal completion: no abort.
- Simultaneous done and a counter hit counts as a normal completion: no timeout.
- Requests from non-winners during BUSY are ignored until IDLE. There is no preemption.
- sel changes only on the cycle grant changes from zero to nonzero. During the IDLE gap sel holds its previous value, which is harmless because grant=0.
- Invariants:
  - grant is zero or exactly one-hot.
  - busy equals |grant.
  - timeout and abort are never high together.
  - sel<NUM_REQ always.
- Fairness: a continuously asserting requester is granted within NUM_REQ grants.

Test Plan (NUM_REQ=4, HOLD_MAX=8):
- Reset then req=4'b0101 in IDLE → next cycle grant=0001, sel=0, busy=1; done pulse 3 cycles later → grant=0 next cycle; one cycle after that grant=0100, sel=2.
- req=4'b1111 held, done asserted 1 cycle after each grant → grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- req=4'b0010 held, done never asserted → grant=0010 for exactly 8 cycles, then timeout=1 for one cycle with grant=0, ptr=2; next grant 0010 again after the idle cycle.
- Grant active on requester 3, req[3] drops at cycle 2 with done=0 → abort=1 for one cycle, grant=0; same test with done=1 in that cycle → abort=0.
- rst=1 asserted mid-BUSY (grant=0100) → next cycle all outputs 0, ptr=0; with req=1111 after reset, first grant=0001.
- Random req/done for 10k cycles → one-hot, busy, and timeout/abort-exclusivity invariants hold; no requester waits more than 4 grants while held high.
